lmsm_sequencer: RTL
===================

Name: lmsm_sequencer

Overview:
- Parametrised multi-register load/store micro-op sequencer. It sits between the decode stage and the register-read stage.
- On an LM/SM instruction it takes the base address and the register bitmask. It then issues one single-register memory micro-op per cycle, lowest register first, with consecutive memory addresses.
- It holds fetch/decode stalled until the sequence completes or is flushed. It generalises the single-cycle LM/SM handling in decode to any register count, address width and address stride, and adds backpressure and flush.

Parameters:
- NUM_REGS, 8, number of architectural registers; width of the register mask.
- REG_AW, 3, register address width; must be at least clog2(NUM_REGS).
- ADDR_W, 16, data-memory address width.
- ADDR_STRIDE, 1, address increment between successive micro-ops, in ADDR_W-bit units.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  decode presents an LM/SM instruction this cycle.
- is_store  in  1  1 = SM, 0 = LM; sampled with start.
- base_addr  in  ADDR_W  RA contents (start address); sampled with start.
- reg_mask  in  NUM_REGS  register-select bitmask, bit i = register i; sampled with start.
- flush  in  1  branch/jump squash from a later stage.
- uop_ready  in  1  downstream accepts the current micro-op.
- busy  out  1  sequence in progress (state RUN or DONE).
- stall_fetch  out  1  hold PC and the IF/ID pipe register.
- uop_valid  out  1  micro-op outputs are valid.
- uop_is_store  out  1  micro-op is a store.
- uop_reg  out  REG_AW  register to load into, or to read for storing.
- uop_addr  out  ADDR_W  memory address for this micro-op.
- uop_last  out  1  final micro-op of the sequence.
- done  out  1  one-cycle pulse at sequence completion.

Behaviour:
- Clock and reset: single clock, clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; internal mask, address and is_store registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with flush=0 accepts the instruction and latches is_store, base_addr and reg_mask.
  - Nonzero mask: go to RUN. On the same edge, load the micro-op registers with the lowest set bit index, addr=base_addr, and uop_last=(mask has exactly one set bit). uop_valid=1 from the next cycle, so latency is 1 cycle.
  - Zero mask: go to DONE; no micro-ops are issued.
  - start with flush=1 is ignored.
- RUN:
  - Outputs are held stable while uop_valid=1 and uop_ready=0.
  - On uop_valid & uop_ready & !uop_last: clear the issued bit, present the next lowest set bit, and set addr = addr + ADDR_STRIDE.
  - Address arithmetic is modulo 2^ADDR_W (wraps, no error).
  - The address advances per issued micro-op, not per mask bit position, so addresses are dense.
  - On a handshake with uop_last=1: uop_valid falls to 0 and the state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A new start is accepted from IDLE only.
- start while busy is ignored. Decode holds the instruction because stall_fetch is high.
- stall_fetch is combinational: (start & !flush & state==IDLE) | (state!=IDLE). It rises in the same cycle start is presented and falls in the cycle after done.
- flush in any state: on the next edge go to IDLE, clear uop_valid, suppress done, and discard the mask. flush overrides a simultaneous handshake; that micro-op counts as not issued.
- Register index: bits at or above NUM_REGS do not exist, so the priority encoder covers only NUM_REGS bits.
- Reset mid-sequence: immediate return to reset values; no done.
- Micro-op count per sequence equals popcount(reg_mask). Register indices strictly increase.

Test Plan:
- Basic LM: start, is_store=0, base=0x0040, mask=8'b1010_0101, uop_ready=1 → uops (reg 0, 0x40), (2, 0x41), (5, 0x42), (7, 0x43 with last). The first uop_valid is in the cycle after start, uops follow on consecutive cycles, done fires 1 cycle after the last handshake, and stall_fetch is high from the start cycle through the done cycle.
- Backpressure SM: mask=8'b0001_1000, base=0x1000, uop_ready low for 3 cycles on the first uop → reg 3 / 0x1000 held stable for 3 cycles; then (4, 0x1001, last), done; uop_is_store=1 throughout.
- Empty mask: start, mask=0 → no uop_valid; done 1 cycle after start; stall_fetch high for 2 cycles total.
- Wrap and stride: ADDR_STRIDE=2, base=0xFFFE, mask=8'b0000_0111 → addresses 0xFFFE, 0x0000, 0x0002.
- Flush mid-sequence: mask=8'hFF, flush asserted coincident with the third handshake → IDLE next cycle; only 2 uops counted as issued; done never pulses; a new start is accepted immediately after.
- Parametrised and reset: NUM_REGS=16, REG_AW=4, mask=16'h8001 → regs 0 then 15. Async rst_n low during RUN → all outputs 0 with no clock edge; the sequence is not resumed after release.

Source files
------------

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: expands one LM/SM instruction into single-register memory micro-ops.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, is_store     decode presents LM (0) / SM (1); sampled in IDLE
//   base_addr, reg_mask start address and register bitmask; sampled with start
//   flush               squash: return to IDLE on the next edge, no done
//   uop_ready           downstream accepts the current micro-op
//   busy, stall_fetch   sequence in progress / hold PC and IF/ID
//   uop_valid, uop_is_store, uop_reg, uop_addr, uop_last  current micro-op
//   done                one-cycle pulse when the sequence completes
module lmsm_sequencer #(
  parameter int NUM_REGS    = 8,
  parameter int REG_AW      = 3,
  parameter int ADDR_W      = 16,
  parameter int ADDR_STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NUM_REGS-1:0] reg_mask,
  input  logic              flush,
  input  logic              uop_ready,
  output logic              busy,
  output logic              stall_fetch,
  output logic              uop_valid,
  output logic              uop_is_store,
  output logic [REG_AW-1:0] uop_reg,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_last,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  // Registers still to issue, excluding the one currently presented.
  logic [NUM_REGS-1:0] rem;
  logic [NUM_REGS-1:0] start_rem;
  logic [NUM_REGS-1:0] next_rem;
  function automatic logic [REG_AW-1:0] lowest(input logic [NUM_REGS-1:0] m);
    lowest = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) if (m[i]) lowest = REG_AW'(i);
  endfunction
  function automatic logic [NUM_REGS-1:0] drop_lowest(input logic [NUM_REGS-1:0] m);
    return m & (m - NUM_REGS'(1));
  endfunction
  assign start_rem   = drop_lowest(reg_mask);
  assign next_rem    = drop_lowest(rem);
  assign busy        = state != IDLE;
  assign stall_fetch = (start & ~flush & (state == IDLE)) | busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rem          <= '0;
      uop_valid    <= 1'b0;
      uop_is_store <= 1'b0;
      uop_reg      <= '0;
      uop_addr     <= '0;
      uop_last     <= 1'b0;
      done         <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      rem       <= '0;
      uop_valid <= 1'b0;
      uop_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          uop_is_store <= is_store;
          uop_addr     <= base_addr;
          uop_reg      <= lowest(reg_mask);
          rem          <= start_rem;
          uop_last     <= (|reg_mask) & (start_rem == '0);
          uop_valid    <= |reg_mask;
          done         <= ~|reg_mask;
          state        <= (|reg_mask) ? RUN : DONE;
        end
        RUN: if (uop_ready) begin
          if (uop_last) begin
            uop_valid <= 1'b0;
            uop_last  <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            uop_reg  <= lowest(rem);
            rem      <= next_rem;
            uop_last <= next_rem == '0;
            uop_addr <= uop_addr + ADDR_W'(ADDR_STRIDE);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
